// File: rtl/msb_locate_arbiter_pkg.sv
// Shared types and defaults for the shared leading-one (sqrt exponent seed) locator.
package msb_locate_pkg;

    localparam int N_REQ_DEF     = 4;
    localparam int N_REQ_MAX     = 8;
    localparam int WIDTH_DEF     = 12;
    localparam int FRAC_BITS_DEF = 4;
    localparam int LOC_W         = 6;
    // Tags are sized for the largest supported requester count so any N_REQ in 2..8 fits.
    localparam int TAG_W         = $clog2(N_REQ_MAX);

    typedef logic [LOC_W-1:0] loc_t;
    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
        logic found;
        loc_t loc;
    } stage_t;

    // Round-robin successor; explicit compare so non-power-of-two counts wrap correctly.
    function automatic tag_t rr_next(input tag_t idx, input int n);
        return ((int'(idx) + 1) >= n) ? '0 : tag_t'(int'(idx) + 1);
    endfunction

endpackage

// File: rtl/msb_locate_arbiter_half_locate.sv
// Pure combinational locator: found = (ivec != 0), loc = ceil(msb/2) expressed as (msb+1)>>1.
module msb_half_locate
    import msb_locate_pkg::*;
#(
    parameter int IW = WIDTH_DEF - FRAC_BITS_DEF
) (
    input  logic [IW-1:0] i_ivec,
    output logic          o_found,
    output loc_t          o_loc
);

    loc_t w_msb;

    // Scan upward so the last set bit seen is the most significant one.
    always_comb begin
        w_msb = '0;
        for (int i = 0; i < IW; i++) begin
            w_msb = i_ivec[i] ? LOC_W'(i) : w_msb;
        end
    end

    assign o_found = |i_ivec;
    assign o_loc   = o_found ? loc_t'((w_msb + loc_t'(1'b1)) >> 1) : '0;

endmodule

// File: rtl/msb_locate_arbiter.sv
// Round-robin arbiter in front of a tagged two-stage locator pipeline with a demuxed response pulse.
module msb_locate_arbiter
    import msb_locate_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_,
    input  logic                   i_hold,
    input  logic [N_REQ-1:0]       i_req_valid,
    input  logic [N_REQ*WIDTH-1:0] i_req_vector,
    output logic [N_REQ-1:0]       o_req_ready,
    output logic [N_REQ-1:0]       o_resp_valid,
    output loc_t                   o_resp_location,
    output logic                   o_resp_found,
    output logic [1:0]             o_in_flight
);

    localparam int IW = WIDTH - FRAC_BITS;
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    tag_t             r_rr_ptr;
    logic             r_s1_valid;
    tag_t             r_s1_tag;
    logic [IW-1:0]    r_s1_ivec;
    stage_t           r_s2;
    logic [N_REQ-1:0] r_resp_valid;
    loc_t             r_resp_location;
    logic             r_resp_found;

    logic             w_grant_hit;
    tag_t             w_grant_idx;
    logic [WIDTH-1:0] w_grant_vec;
    logic             w_xfer;
    logic             w_found;
    loc_t             w_loc;
    int               w_dist;
    int               w_best_dist;

    // Pick the valid requester closest to rr_ptr going upward (modulo N_REQ).
    always_comb begin
        w_grant_hit = 1'b0;
        w_grant_idx = '0;
        w_grant_vec = '0;
        w_best_dist = N_REQ;
        w_dist      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_dist = (i + N_REQ - int'(r_rr_ptr)) % N_REQ;
            if (i_req_valid[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_grant_hit = 1'b1;
                w_grant_idx = tag_t'(i);
                w_grant_vec = i_req_vector[i*WIDTH +: WIDTH];
            end else begin
                w_best_dist = w_best_dist;
            end
        end
    end

    assign w_xfer      = w_grant_hit & ~i_hold & i_rst_;
    assign o_req_ready = w_xfer ? (ONE << w_grant_idx) : '0;

    msb_half_locate #(
        .IW (IW)
    ) u_locate (
        .i_ivec  (r_s1_ivec),
        .o_found (w_found),
        .o_loc   (w_loc)
    );

    // Pointer, capture/locate stages and response registers; hold freezes all, reset overrides hold.
    always_ff @(posedge i_clk) begin
        if (!i_rst_) begin
            r_rr_ptr        <= '0;
            r_s1_valid      <= 1'b0;
            r_s1_tag        <= '0;
            r_s1_ivec       <= '0;
            r_s2            <= '0;
            r_resp_valid    <= '0;
            r_resp_location <= '0;
            r_resp_found    <= 1'b0;
        end else if (!i_hold) begin
            if (w_xfer) begin
                r_rr_ptr   <= rr_next(w_grant_idx, N_REQ);
                r_s1_valid <= 1'b1;
                r_s1_tag   <= w_grant_idx;
                r_s1_ivec  <= IW'(w_grant_vec >> FRAC_BITS);
            end else begin
                r_s1_valid <= 1'b0;
            end
            r_s2         <= '{valid: r_s1_valid, tag: r_s1_tag, found: w_found, loc: w_loc};
            r_resp_valid <= r_s2.valid ? (ONE << r_s2.tag) : '0;
            // Location/found persist until the next result rather than clearing after the pulse.
            if (r_s2.valid) begin
                r_resp_location <= r_s2.loc;
                r_resp_found    <= r_s2.found;
            end
        end
    end

    // The pulse is masked while frozen so it re-presents intact once hold drops.
    assign o_resp_valid    = i_hold ? '0 : r_resp_valid;
    assign o_resp_location = r_resp_location;
    assign o_resp_found    = r_resp_found;
    assign o_in_flight     = {1'b0, r_s1_valid} + {1'b0, r_s2.valid};

endmodule

// File: tb/tb_msb_locate_arbiter.sv
// Scoreboard bench: stimulus pushes expected responses, an independent monitor pops on each pulse.
module tb_msb_locate_arbiter;

    localparam int N  = 4;
    localparam int W  = 12;
    localparam int FB = 4;

    logic           clk = 1'b0;
    logic           rst_;
    logic           hold;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_vector;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_valid;
    logic [5:0]     resp_location;
    logic           resp_found;
    logic [1:0]     in_flight;

    always #5 clk = ~clk;

    msb_locate_arbiter dut (
        .i_clk           (clk),
        .i_rst_          (rst_),
        .i_hold          (hold),
        .i_req_valid     (req_valid),
        .i_req_vector    (req_vector),
        .o_req_ready     (req_ready),
        .o_resp_valid    (resp_valid),
        .o_resp_location (resp_location),
        .o_resp_found    (resp_found),
        .o_in_flight     (in_flight)
    );

    typedef struct {
        int tag;
        int loc;
        bit found;
    } exp_t;

    exp_t         exp_q[$];
    int           n_vec = 0;
    int           n_bad = 0;
    int           rr = 0;
    bit           h0 = 1'b0;
    bit           h1 = 1'b0;
    int           last_g = -1;
    bit           v[N];
    logic [W-1:0] vec[N];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Seed = half the bit length of the integer part (bit length = msb+1).
    function automatic int ref_loc(input logic [W-1:0] x);
        int iv;
        int b;
        iv = int'(x >> FB);
        b  = 0;
        while (iv > 0) begin
            b++;
            iv = iv >> 1;
        end
        return b / 2;
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] tbl [5];
        tbl[0] = 12'h0A0; tbl[1] = 12'h010; tbl[2] = 12'h00F; tbl[3] = 12'hFFF; tbl[4] = 12'h000;
        if ($urandom_range(3) == 0) return tbl[$urandom_range(4)];
        return W'($urandom & 32'hFFF) >> $urandom_range(11);
    endfunction

    task automatic cycle(input bit chk_resp = 1'b0, input logic [N-1:0] exp_resp = '0);
        int g;
        logic [N-1:0] exp_rdy;
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = v[i];
            req_vector[i*W +: W] = vec[i];
        end
        @(negedge clk);
        g = -1;
        if (rst_ && !hold) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && v[(rr + k) % N]) g = (rr + k) % N;
            end
        end
        exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("req_ready", int'(req_ready), int'(exp_rdy));
        chk("in_flight", int'(in_flight), int'(h0) + int'(h1));
        if (chk_resp) chk("resp_valid", int'(resp_valid), int'(exp_resp));
        if (g >= 0) begin
            exp_q.push_back('{g, ref_loc(vec[g]), ((vec[g] >> FB) != 0)});
            rr = (g + 1) % N;
        end
        @(posedge clk);
        if (!rst_) begin
            rr = 0; h0 = 1'b0; h1 = 1'b0;
            exp_q.delete();
        end else if (!hold) begin
            h1 = h0;
            h0 = (g >= 0);
        end
        last_g = g;
        #1;
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", int'(resp_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_tag", int'(resp_valid), 1 << e.tag);
                    chk("resp_loc", int'(resp_location), e.loc);
                    chk("resp_found", int'(resp_found), int'(e.found));
                end
            end
        end
    end

    initial begin
        logic [W-1:0] dvec [4];
        int dloc [4];
        bit dfnd [4];
        dvec[0] = 12'h0A0; dloc[0] = 2; dfnd[0] = 1'b1;
        dvec[1] = 12'h010; dloc[1] = 0; dfnd[1] = 1'b1;
        dvec[2] = 12'h00F; dloc[2] = 0; dfnd[2] = 1'b0;
        dvec[3] = 12'hFFF; dloc[3] = 4; dfnd[3] = 1'b1;

        rst_ = 1'b0; hold = 1'b0;
        for (int i = 0; i < N; i++) begin v[i] = 1'b1; vec[i] = rand_vec(); end
        for (int i = 0; i < N; i++) begin req_valid[i] = v[i]; req_vector[i*W +: W] = vec[i]; end
        @(posedge clk); #1;
        cycle(1'b1, 4'b0000);
        rst_ = 1'b1;
        for (int i = 0; i < N; i++) v[i] = 1'b0;
        chk("rst_loc", int'(resp_location), 0);
        chk("rst_found", int'(resp_found), 0);
        chk("rst_resp", int'(resp_valid), 0);

        // Single requester, known vectors, exact latency.
        for (int d = 0; d < 4; d++) begin
            v[0] = 1'b1; vec[0] = dvec[d];
            cycle();
            chk("dir_grant", last_g, 0);
            v[0] = 1'b0;
            cycle();
            cycle();
            cycle(1'b1, 4'b0001);
            chk("dir_loc", int'(resp_location), dloc[d]);
            chk("dir_found", int'(resp_found), int'(dfnd[d]));
        end

        // All requesters valid: strict rotation starting after requester 0.
        for (int i = 0; i < N; i++) begin v[i] = 1'b1; vec[i] = rand_vec(); end
        for (int k = 0; k < 12; k++) begin
            cycle();
            chk("rr_order", last_g, (1 + k) % N);
            if (last_g >= 0) vec[last_g] = rand_vec();
        end
        chk("flight_full", int'(in_flight), 2);
        for (int i = 0; i < N; i++) v[i] = 1'b0;
        repeat (4) cycle();

        // Pointer wrap: grant 2, then 3, then wrap past 0 to 1.
        v[2] = 1'b1; vec[2] = rand_vec();
        cycle();
        chk("wrap_g2", last_g, 2);
        v[2] = 1'b0; v[1] = 1'b1; v[3] = 1'b1; vec[1] = rand_vec(); vec[3] = rand_vec();
        cycle();
        chk("wrap_g3", last_g, 3);
        v[3] = 1'b0;
        cycle();
        chk("wrap_g1", last_g, 1);
        v[1] = 1'b0;
        repeat (4) cycle();

        // Hold with two in flight.
        v[0] = 1'b1; v[1] = 1'b1; vec[0] = rand_vec(); vec[1] = rand_vec();
        cycle();
        v[last_g] = 1'b0;
        cycle();
        for (int i = 0; i < N; i++) v[i] = 1'b0;
        v[2] = 1'b1; vec[2] = rand_vec();
        hold = 1'b1;
        repeat (3) cycle(1'b1, 4'b0000);
        chk("hold_flight", int'(in_flight), 2);
        hold = 1'b0;
        cycle(1'b1, 4'b0000);
        v[2] = 1'b0;
        cycle(1'b1, 4'b0001);
        cycle(1'b1, 4'b0010);
        repeat (3) cycle();

        // Reset with two in flight drops them.
        v[0] = 1'b1; v[1] = 1'b1; vec[0] = rand_vec(); vec[1] = rand_vec();
        cycle();
        v[last_g] = 1'b0;
        cycle();
        for (int i = 0; i < N; i++) v[i] = 1'b0;
        rst_ = 1'b0;
        cycle();
        rst_ = 1'b1;
        chk("rst_flight", int'(in_flight), 0);
        repeat (4) cycle(1'b1, 4'b0000);
        for (int i = 0; i < N; i++) begin v[i] = 1'b1; vec[i] = rand_vec(); end
        cycle();
        chk("post_rst_grant", last_g, 0);
        v[0] = 1'b0;

        // Randomized traffic with occasional hold and reset.
        for (int c = 0; c < 400; c++) begin
            hold = ($urandom_range(9) == 0);
            rst_ = ($urandom_range(79) != 0);
            for (int i = 0; i < N; i++) begin
                if (!v[i]) begin
                    if ($urandom_range(2) == 0) begin v[i] = 1'b1; vec[i] = rand_vec(); end
                end else if ($urandom_range(19) == 0) begin
                    v[i] = 1'b0;
                end
            end
            cycle();
            if (last_g >= 0) v[last_g] = 1'b0;
        end

        hold = 1'b0; rst_ = 1'b1;
        for (int i = 0; i < N; i++) v[i] = 1'b0;
        repeat (6) cycle();
        chk("drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
